// File: rtl/tracker_pkg.sv
// Shared definitions for the tracker display path: scheduler states and the
// BCD range limits used when converting binary counters.
package tracker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_STEP,
    WAIT_STEP,
    CHK_DIST,
    WAIT_DIST,
    COMMIT
  } state_t;

  localparam int unsigned BCD_MAX_BIN = 9999;
  localparam logic [15:0] BCD_SAT     = 16'h9999;

endpackage

// File: rtl/refresh_timer.sv
// Free-running refresh divider: counts 0..DIV-1 while enabled, one-cycle tick
// on the wrap cycle, held at zero while disabled.
module refresh_timer #(
  parameter int unsigned DIV = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one bin2bcd converter between the step and distance counters and
// publishes both BCD results as one coherent, registered pair.
module bcd_conv_scheduler
  import tracker_pkg::*;
#(
  parameter int unsigned BIN_W          = 16,
  parameter int unsigned BCD_W          = 16,
  parameter int unsigned REFRESH_CYCLES = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk100Mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             force_refresh,
  input  logic [BIN_W-1:0] step_count,
  input  logic [BIN_W-1:0] distance,
  output logic             conv_start,
  output logic [BIN_W-1:0] conv_bin,
  input  logic             conv_done,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic [BCD_W-1:0] bcd_step_count,
  output logic [BCD_W-1:0] bcd_distance,
  output logic             valid,
  output logic             busy,
  output logic             sat_flag,
  output logic             timeout_err
);

  // state     | meaning
  // IDLE      | waiting for a refresh request (timer tick, force or pending)
  // CHK_STEP  | range-check step snapshot, start its conversion
  // WAIT_STEP | waiting for step result or timeout
  // CHK_DIST  | range-check distance snapshot, start its conversion
  // WAIT_DIST | waiting for distance result or timeout
  // COMMIT    | pair visible on outputs, valid pulses

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(BCD_MAX_BIN);
  localparam logic [BCD_W-1:0] SAT_BCD   = BCD_W'(BCD_SAT);
  localparam logic [TW-1:0]    WAIT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic             tick, request, take, wait_load, timeout_hit, pending;
  logic [BIN_W-1:0] snap_step, snap_dist;
  logic [BCD_W-1:0] step_res, dist_res, step_res_d, dist_res_d;
  logic             step_sat, dist_sat, step_sat_d, dist_sat_d;
  logic [TW-1:0]    wait_cnt;

  refresh_timer #(.DIV(REFRESH_CYCLES)) u_refresh_timer (
    .clk    (clk100Mhz),
    .rst_n  (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign request = tick | force_refresh;
  assign busy    = (state != IDLE);
  assign valid   = (state == COMMIT);

  always_ff @(posedge clk100Mhz or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    conv_start  = 1'b0;
    conv_bin    = '0;
    take        = 1'b0;
    wait_load   = 1'b0;
    timeout_hit = 1'b0;
    step_res_d  = step_res;
    dist_res_d  = dist_res;
    step_sat_d  = step_sat;
    dist_sat_d  = dist_sat;
    case (state)
      IDLE: begin
        if (enable && (request || pending)) begin
          take       = 1'b1;
          next_state = CHK_STEP;
        end
      end
      CHK_STEP: begin
        conv_bin = snap_step;
        if (snap_step > MAX_BIN) begin
          step_res_d = SAT_BCD;
          step_sat_d = 1'b1;
          next_state = CHK_DIST;
        end else begin
          // A timed-out conversion falls back to the last published value.
          step_res_d = bcd_step_count;
          step_sat_d = 1'b0;
          conv_start = 1'b1;
          wait_load  = 1'b1;
          next_state = WAIT_STEP;
        end
      end
      WAIT_STEP: begin
        conv_bin = snap_step;
        if (conv_done) begin
          step_res_d = conv_bcd;
          next_state = CHK_DIST;
        end else if (wait_cnt == '0) begin
          timeout_hit = 1'b1;
          next_state  = CHK_DIST;
        end
      end
      CHK_DIST: begin
        conv_bin = snap_dist;
        if (snap_dist > MAX_BIN) begin
          dist_res_d = SAT_BCD;
          dist_sat_d = 1'b1;
          next_state = COMMIT;
        end else begin
          dist_res_d = bcd_distance;
          dist_sat_d = 1'b0;
          conv_start = 1'b1;
          wait_load  = 1'b1;
          next_state = WAIT_DIST;
        end
      end
      WAIT_DIST: begin
        conv_bin = snap_dist;
        if (conv_done) begin
          dist_res_d = conv_bcd;
          next_state = COMMIT;
        end else if (wait_cnt == '0) begin
          timeout_hit = 1'b1;
          next_state  = COMMIT;
        end
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk100Mhz or negedge rst) begin
    if (!rst) begin
      pending        <= 1'b0;
      snap_step      <= '0;
      snap_dist      <= '0;
      step_res       <= '0;
      dist_res       <= '0;
      step_sat       <= 1'b0;
      dist_sat       <= 1'b0;
      wait_cnt       <= '0;
      bcd_step_count <= '0;
      bcd_distance   <= '0;
      sat_flag       <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      step_res <= step_res_d;
      dist_res <= dist_res_d;
      step_sat <= step_sat_d;
      dist_sat <= dist_sat_d;

      if (state == IDLE)  pending <= 1'b0;
      else if (request)   pending <= 1'b1;

      if (take) begin
        snap_step <= step_count;
        snap_dist <= distance;
      end

      if (wait_load)            wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - TW'(1);

      if (timeout_hit) timeout_err <= 1'b1;

      // Load on entry so the pair is on the outputs during the COMMIT cycle.
      if (next_state == COMMIT) begin
        bcd_step_count <= step_res_d;
        bcd_distance   <= dist_res_d;
        sat_flag       <= step_sat_d | dist_sat_d;
      end
    end
  end

endmodule
